// File: rtl/id_ex_register_pkg.sv
// Shared pipeline definitions: control-word packing, ALU op encodings and the
// all-zero control word that a bubble carries.
package id_ex_register_pkg;

    localparam int CTRL_W = 10;

    // Bit positions inside the packed control word (MSB first)
    localparam int CTRL_REG_DST    = 9;
    localparam int CTRL_ALU_SRC    = 8;
    localparam int CTRL_ALU_OP_HI  = 7;
    localparam int CTRL_ALU_OP_LO  = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_JUMP       = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    // A bubble never writes memory, registers, or redirects the PC
    localparam ctrl_t CTRL_NOP = '0;

    // Pass the control word only for a real instruction
    function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle stage with flush, hold and load-use
// bubble insertion, plus a saturating count of bubbles loaded.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              stall,
    input  logic              valid_in,
    input  logic              cnt_clear,
    input  logic [9:0]        ctrl_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    output logic              valid_out,
    output logic [9:0]        ctrl_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic vld_p0;
    logic load_p0;
    logic bubble_inc;

    // Entry validity if this edge performs a normal load
    assign vld_p0 = valid_in & ~stall;

    // Flush overrides hold, so either one loads the data fields
    assign load_p0 = flush | ~hold;

    // A bubble is counted whenever an invalid entry is actually written
    assign bubble_inc = flush | (~hold & ~vld_p0);

    // ID -> EX stage boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out    <= 1'b0;
            ctrl_out     <= CTRL_NOP;
            pc_plus4_out <= '0;
            rd1_out      <= '0;
            rd2_out      <= '0;
            imm_out      <= '0;
            rs_out       <= '0;
            rt_out       <= '0;
            rd_out       <= '0;
        end else if (load_p0) begin
            valid_out    <= vld_p0 & ~flush;
            ctrl_out     <= ctrl_gate(vld_p0 & ~flush, ctrl_in);
            pc_plus4_out <= pc_plus4_in;
            rd1_out      <= rd1_in;
            rd2_out      <= rd2_in;
            imm_out      <= imm_in;
            rs_out       <= rs_in;
            rt_out       <= rt_in;
            rd_out       <= rd_in;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .clr   (cnt_clear),
        .cnt   (bubble_cnt)
    );

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set datapath field width.
REQ-002 Parameter CNT_W, default 16, SHALL set bubble counter width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high.
REQ-005 flush  input  1  branch/jump taken in EX; squash entry being loaded.
REQ-006 hold  input  1  freeze register contents (downstream not ready).
REQ-007 stall  input  1  load-use hazard bubble; same signal that zeroes the ID control mux.
REQ-008 valid_in  input  1  ID holds a real instruction.
REQ-009 cnt_clear  input  1  synchronous clear of bubble_cnt.
REQ-010 ctrl_in  input  10  packed {reg_dst, alu_src, alu_op[1:0], branch, mem_read, mem_write, reg_write, mem_to_reg, jump}, MSB first.
REQ-011 pc_plus4_in  input  DATA_W  PC+4 of ID instruction.
REQ-012 rd1_in  input  DATA_W  register file read port 1.
REQ-013 rd2_in  input  DATA_W  register file read port 2.
REQ-014 imm_in  input  DATA_W  sign-extended immediate.
REQ-015 rs_in  input  5  rs field.
REQ-016 rt_in  input  5  rt field.
REQ-017 rd_in  input  5  rd field.
REQ-018 valid_out  output  1  EX entry is a real instruction.
REQ-019 ctrl_out  output  10  registered ctrl_in, same packing.
REQ-020 pc_plus4_out, rd1_out, rd2_out, imm_out  output  DATA_W each  registered copies.
REQ-021 rs_out, rt_out, rd_out  output  5 each  registered copies (forwarding unit reads rs_out/rt_out).
REQ-022 bubble_cnt  output  CNT_W  count of invalid entries loaded.

Function
REQ-023 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-024 Per-edge priority SHALL be reset > flush > hold > normal load.
REQ-025 Flush SHALL load valid_out=0 and ctrl_out=0; data fields SHALL load normally (don't-care); flush overrides hold.
REQ-026 Hold (without flush) SHALL keep every output field, including valid_out, unchanged; bubble_cnt SHALL not increment.
REQ-027 Normal load SHALL set valid_out = valid_in & ~stall; ctrl_out = ctrl_in if the new valid is 1, else 0 (bubble SHALL never carry mem_write/reg_write/branch/jump).
REQ-028 bubble_cnt SHALL increment by 1 on each edge that loads valid_out=0 via flush or normal load, saturating at all-ones (no wrap).
REQ-029 cnt_clear SHALL zero bubble_cnt; cnt_clear together with an increment SHALL yield 0.
REQ-030 stall and flush together SHALL behave as flush (single increment).
REQ-031 Outputs SHALL be driven only from flops; no combinational input-to-output path.

Reset
REQ-032 Reset assertion SHALL immediately force all outputs to 0 (valid_out=0, ctrl_out=0, bubble_cnt=0), independent of clk.
REQ-033 Reset deassertion mid-operation SHALL resume with normal load on the next edge; no entry from before reset SHALL reappear.

Structure
REQ-034 The control packing (field bit positions), ALU_OP encodings (00 add, 01 sub, 10 R-type), and the 10-bit CTRL_NOP constant SHALL live in the shared pipeline package.
REQ-035 One sub-module, sat_counter (CNT_W, inc, clr), SHALL implement bubble_cnt; the rest is flat.

Verification
REQ-036 Reset then load valid_in=1, ctrl_in=10'h2C2, rd1_in=32'h1234 -> next cycle valid_out=1, ctrl_out=10'h2C2, rd1_out=32'h1234.
REQ-037 stall=1 with ctrl_in=10'h2C2 -> valid_out=0, ctrl_out=0, bubble_cnt +1.
REQ-038 hold=1 for 3 cycles with changing inputs -> outputs constant, bubble_cnt constant; hold+flush -> valid_out=0, ctrl_out=0.
REQ-039 Preload bubble_cnt to 16'hFFFE via bubbles, 3 more flushes -> bubble_cnt stays 16'hFFFF; cnt_clear with flush -> 0.
REQ-040 Assert reset between edges while valid_out=1 -> outputs 0 before next clk edge; first post-reset load matches inputs.
